// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - AXI encodings and line-master state type
package axi_pkg;

    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RADDR,
        ST_RDATA,
        ST_WADDR,
        ST_WDATA,
        ST_WRESP,
        ST_DONE
    } line_state_e;

endpackage

// File: rtl/axi_line_buffer.sv
// rtl/axi_line_buffer.sv - cache line register file, beat-indexed write, whole-line load, flat read
module axi_line_buffer #(
    parameter int DATA_W     = 64,
    parameter int LINE_BEATS = 2,
    parameter int IDX_W      = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         load,
    input  logic [DATA_W*LINE_BEATS-1:0] load_line,
    input  logic                         wr_en,
    input  logic [IDX_W-1:0]             wr_idx,
    input  logic [DATA_W-1:0]            wr_data,
    output logic [DATA_W*LINE_BEATS-1:0] line
);

    logic [DATA_W*LINE_BEATS-1:0] line_q;

    // A whole-line load takes priority; the FSM never asserts both together.
    always_ff @(posedge clock) begin
        if (!reset) begin
            line_q <= '0;
        end else if (load) begin
            line_q <= load_line;
        end else if (wr_en) begin
            for (int i = 0; i < LINE_BEATS; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    line_q[i*DATA_W +: DATA_W] <= wr_data;
                end
            end
        end
    end

    assign line = line_q;

endmodule

// File: rtl/axi_line_master.sv
// rtl/axi_line_master.sv - turns one cache line refill/writeback into a single AXI4 INCR burst
module axi_line_master
    import axi_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int LINE_BEATS = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         io_req_valid,
    output logic                         io_req_ready,
    input  logic                         io_req_write,
    input  logic [ADDR_W-1:0]            io_req_addr,
    input  logic [DATA_W*LINE_BEATS-1:0] io_req_wline,
    output logic                         io_resp_valid,
    input  logic                         io_resp_ready,
    output logic [DATA_W*LINE_BEATS-1:0] io_resp_rline,
    output logic                         io_resp_err,
    output logic                         io_ar_valid,
    input  logic                         io_ar_ready,
    output logic [ADDR_W-1:0]            io_ar_addr,
    output logic [7:0]                   io_ar_len,
    output logic [2:0]                   io_ar_size,
    output logic [1:0]                   io_ar_burst,
    input  logic                         io_r_valid,
    output logic                         io_r_ready,
    input  logic [DATA_W-1:0]            io_r_data,
    input  logic [1:0]                   io_r_resp,
    input  logic                         io_r_last,
    output logic                         io_aw_valid,
    input  logic                         io_aw_ready,
    output logic [ADDR_W-1:0]            io_aw_addr,
    output logic [7:0]                   io_aw_len,
    output logic [2:0]                   io_aw_size,
    output logic [1:0]                   io_aw_burst,
    output logic                         io_w_valid,
    input  logic                         io_w_ready,
    output logic [DATA_W-1:0]            io_w_data,
    output logic [7:0]                   io_w_strb,
    output logic                         io_w_last,
    input  logic                         io_b_valid,
    output logic                         io_b_ready,
    input  logic [1:0]                   io_b_resp
);

    localparam int IDX_W = $clog2(LINE_BEATS);
    localparam int CNT_W = IDX_W + 1;
    localparam int OFF_W = $clog2(LINE_BEATS * 8);
    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(LINE_BEATS - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

    line_state_e         state;
    logic [CNT_W-1:0]    cnt;
    logic                err;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W*LINE_BEATS-1:0] line;
    logic [DATA_W-1:0]   w_beat;
    logic                last_beat;

    assign last_beat = (cnt == LAST_CNT);

    axi_line_buffer #(
        .DATA_W     (DATA_W),
        .LINE_BEATS (LINE_BEATS),
        .IDX_W      (IDX_W)
    ) u_buf (
        .clock     (clock),
        .reset     (reset),
        .load      (state == ST_IDLE && io_req_valid),
        .load_line (io_req_wline),
        .wr_en     (state == ST_RDATA && io_r_valid),
        .wr_idx    (cnt[IDX_W-1:0]),
        .wr_data   (io_r_data),
        .line      (line)
    );

    always_comb begin
        w_beat = '0;
        for (int i = 0; i < LINE_BEATS; i++) begin
            if (cnt[IDX_W-1:0] == IDX_W'(i)) begin
                w_beat = line[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            err    <= 1'b0;
            addr_q <= '0;
        end else begin
            case (state)
                ST_IDLE: if (io_req_valid) begin
                    addr_q <= io_req_addr & ALIGN_MASK;
                    cnt    <= '0;
                    err    <= 1'b0;
                    state  <= io_req_write ? ST_WADDR : ST_RADDR;
                end
                ST_RADDR: if (io_ar_ready) state <= ST_RDATA;
                // A misplaced r_last is flagged but the full line is still collected.
                ST_RDATA: if (io_r_valid) begin
                    if (io_r_resp != AXI_RESP_OKAY || io_r_last != last_beat) err <= 1'b1;
                    cnt <= cnt + CNT_W'(1);
                    if (last_beat) state <= ST_DONE;
                end
                ST_WADDR: if (io_aw_ready) state <= ST_WDATA;
                ST_WDATA: if (io_w_ready) begin
                    cnt <= cnt + CNT_W'(1);
                    if (last_beat) state <= ST_WRESP;
                end
                ST_WRESP: if (io_b_valid) begin
                    if (io_b_resp != AXI_RESP_OKAY) err <= 1'b1;
                    state <= ST_DONE;
                end
                ST_DONE: if (io_resp_ready) begin
                    err   <= 1'b0;
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign io_req_ready  = (state == ST_IDLE);
    assign io_resp_valid = (state == ST_DONE);
    assign io_resp_rline = line;
    assign io_resp_err   = err;

    assign io_ar_valid = (state == ST_RADDR);
    assign io_ar_addr  = addr_q;
    assign io_ar_len   = 8'(LINE_BEATS - 1);
    assign io_ar_size  = AXI_SIZE_8B;
    assign io_ar_burst = AXI_BURST_INCR;
    assign io_r_ready  = (state == ST_RDATA);

    assign io_aw_valid = (state == ST_WADDR);
    assign io_aw_addr  = addr_q;
    assign io_aw_len   = 8'(LINE_BEATS - 1);
    assign io_aw_size  = AXI_SIZE_8B;
    assign io_aw_burst = AXI_BURST_INCR;
    assign io_w_valid  = (state == ST_WDATA);
    assign io_w_data   = w_beat;
    assign io_w_strb   = 8'hFF;
    assign io_w_last   = last_beat;
    assign io_b_ready  = (state == ST_WRESP);

endmodule
